// File: rtl/can_pkg.sv
// Shared CAN definitions: field widths, controller result codes and the
// transmit scheduler state encoding.
package can_pkg;

  localparam int CAN_ID_W   = 11;
  localparam int CAN_DATA_W = 64;
  localparam int CAN_KEEP_W = 8;
  localparam int CAN_RES_W  = 3;

  // Controller result codes; anything other than OK is a failed attempt.
  typedef enum logic [CAN_RES_W-1:0] {
    CAN_RES_OK        = 3'd0,
    CAN_RES_ERR_BIT   = 3'd1,
    CAN_RES_ERR_STUFF = 3'd2,
    CAN_RES_ERR_ACK   = 3'd3,
    CAN_RES_ERR_FORM  = 3'd4,
    CAN_RES_ERR_CRC   = 3'd5,
    CAN_RES_ARB_LOST  = 3'd6,
    CAN_RES_BUS_OFF   = 3'd7
  } can_result_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SEND,
    ST_WAIT_RESULT,
    ST_DONE
  } can_tx_sched_state_e;

endpackage

// File: rtl/can_tx_prio_arbiter.sv
// Combinational CAN-ID priority selector: the valid requester with the
// numerically lowest identifier wins, ties resolve to the lowest index.
module can_tx_prio_arbiter
  import can_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0]          req_tvalid,
  input  logic [NUM_REQ*CAN_ID_W-1:0] req_tid,
  output logic [IDX_W-1:0]            win_idx,
  output logic                        win_valid
);

  logic [CAN_ID_W-1:0] best_id;

  // Lowest-ID reduction; the strict compare keeps the earlier index on a tie.
  always_comb begin
    win_valid = 1'b0;
    win_idx   = '0;
    best_id   = '1;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (req_tvalid[i] &&
          (!win_valid || (req_tid[i*CAN_ID_W +: CAN_ID_W] < best_id))) begin
        win_valid = 1'b1;
        win_idx   = IDX_W'(i);
        best_id   = req_tid[i*CAN_ID_W +: CAN_ID_W];
      end
    end
  end

endmodule

// File: rtl/can_tx_scheduler.sv
// Shares one CAN controller transmit stream between NUM_REQ producers.
// Grants by CAN-ID priority, forwards one captured frame at a time, waits for
// its result and pulses a per-requester completion.
// Optional feature macro: CAN_TX_SCHED_RETRY_EN (retry failed frames up to
// MAX_RETRY extra times; retries are never issued while bus-off is high).
module can_tx_scheduler
  import can_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int MAX_RETRY = 3
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ*CAN_DATA_W-1:0] req_tdata,
  input  logic [NUM_REQ*CAN_ID_W-1:0]   req_tid,
  input  logic [NUM_REQ*CAN_KEEP_W-1:0] req_tkeep,
  input  logic [NUM_REQ-1:0]            req_tvalid,
  output logic [NUM_REQ-1:0]            req_tready,
  output logic [NUM_REQ-1:0]            done_valid,
  output logic [CAN_RES_W-1:0]          done_result,
  output logic [CAN_DATA_W-1:0]         stm_send_data_out_tdata,
  output logic [CAN_ID_W-1:0]           stm_send_data_out_tid,
  output logic [CAN_KEEP_W-1:0]         stm_send_data_out_tkeep,
  output logic                          stm_send_data_out_tvalid,
  input  logic                          stm_send_data_out_tready,
  input  logic [CAN_RES_W-1:0]          stm_result_in_tdata,
  input  logic                          stm_result_in_tvalid,
  output logic                          stm_result_in_tready,
  input  logic                          status_bus_off,
  output logic                          busy
);

  localparam int IDX_W = $clog2(NUM_REQ);

`ifdef CAN_TX_SCHED_RETRY_EN
  localparam bit RETRY_EN = 1'b1;
`else
  localparam bit RETRY_EN = 1'b0;
`endif
  localparam int RETRY_MAX = RETRY_EN ? MAX_RETRY : 0;

  can_tx_sched_state_e     state_q, state_d;
  logic [CAN_DATA_W-1:0]   data_q, data_d;
  logic [CAN_ID_W-1:0]     id_q, id_d;
  logic [CAN_KEEP_W-1:0]   keep_q, keep_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic                    tvalid_q, tvalid_d;
  logic                    rready_q, rready_d;
  logic [NUM_REQ-1:0]      done_valid_q, done_valid_d;
  logic [CAN_RES_W-1:0]    done_result_q, done_result_d;

  logic [IDX_W-1:0]        win_idx;
  logic                    win_valid;
  logic                    grant, send_hs, res_hs, res_fail, retry_ok;

  can_tx_prio_arbiter #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_arb (
    .req_tvalid (req_tvalid),
    .req_tid    (req_tid),
    .win_idx    (win_idx),
    .win_valid  (win_valid)
  );

  assign grant    = (state_q == ST_IDLE) && !status_bus_off && win_valid;
  assign send_hs  = tvalid_q && stm_send_data_out_tready;
  assign res_hs   = rready_q && stm_result_in_tvalid;
  assign res_fail = (stm_result_in_tdata != CAN_RES_OK);

`ifdef CAN_TX_SCHED_RETRY_EN
  localparam int CNT_W = (RETRY_MAX > 0) ? $clog2(RETRY_MAX + 1) : 1;

  logic [CNT_W-1:0] attempt_q, attempt_d;

  assign retry_ok = !status_bus_off && (attempt_q < CNT_W'(RETRY_MAX));

  // Attempt counter: cleared on grant, saturating increment per retry.
  always_comb begin
    attempt_d = attempt_q;
    if (grant)
      attempt_d = '0;
    else if (res_hs && res_fail && retry_ok && (attempt_q != '1))
      attempt_d = attempt_q + 1'b1;
  end

  // Attempt counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) attempt_q <= '0;
    else     attempt_q <= attempt_d;
  end
`else
  // Single-attempt build: RETRY_MAX is 0, so this folds to constant 0.
  assign retry_ok = (RETRY_MAX != 0) && !status_bus_off;
`endif

  // Grant strobe goes combinationally to the arbitration winner only.
  always_comb begin
    req_tready = '0;
    if (grant) req_tready[win_idx] = 1'b1;
  end

  // Next-state and next-output computation; stream outputs follow state_d.
  always_comb begin
    state_d       = state_q;
    data_d        = data_q;
    id_d          = id_q;
    keep_d        = keep_q;
    idx_d         = idx_q;
    done_result_d = done_result_q;
    case (state_q)
      ST_IDLE: begin
        if (grant) begin
          data_d  = req_tdata[win_idx*CAN_DATA_W +: CAN_DATA_W];
          id_d    = req_tid[win_idx*CAN_ID_W +: CAN_ID_W];
          keep_d  = req_tkeep[win_idx*CAN_KEEP_W +: CAN_KEEP_W];
          idx_d   = win_idx;
          state_d = ST_SEND;
        end
      end
      ST_SEND: begin
        if (send_hs) state_d = ST_WAIT_RESULT;
      end
      ST_WAIT_RESULT: begin
        if (res_hs) begin
          done_result_d = stm_result_in_tdata;
          state_d       = (res_fail && retry_ok) ? ST_SEND : ST_DONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    tvalid_d     = (state_d == ST_SEND);
    rready_d     = (state_d == ST_WAIT_RESULT);
    done_valid_d = '0;
    if (state_d == ST_DONE) done_valid_d[idx_d] = 1'b1;
  end

  // Scheduler FSM with registered stream and completion outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      data_q        <= '0;
      id_q          <= '0;
      keep_q        <= '0;
      idx_q         <= '0;
      tvalid_q      <= 1'b0;
      rready_q      <= 1'b0;
      done_valid_q  <= '0;
      done_result_q <= '0;
    end else begin
      state_q       <= state_d;
      data_q        <= data_d;
      id_q          <= id_d;
      keep_q        <= keep_d;
      idx_q         <= idx_d;
      tvalid_q      <= tvalid_d;
      rready_q      <= rready_d;
      done_valid_q  <= done_valid_d;
      done_result_q <= done_result_d;
    end
  end

  assign stm_send_data_out_tdata  = data_q;
  assign stm_send_data_out_tid    = id_q;
  assign stm_send_data_out_tkeep  = keep_q;
  assign stm_send_data_out_tvalid = tvalid_q;
  assign stm_result_in_tready     = rready_q;
  assign done_valid               = done_valid_q;
  assign done_result              = done_result_q;
  assign busy                     = (state_q != ST_IDLE);

endmodule

// File: tb/tb_can_tx_scheduler.sv
// Self-checking bench for can_tx_scheduler: expected frames are queued as
// requests are raised and popped as the scheduler serves them.
module tb_can_tx_scheduler;

  localparam int N  = 4;
  localparam int MR = 2;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [N*64-1:0] req_tdata  = '0;
  logic [N*11-1:0] req_tid    = '0;
  logic [N*8-1:0]  req_tkeep  = '0;
  logic [N-1:0]    req_tvalid = '0;
  logic [N-1:0]    req_tready, done_valid;
  logic [2:0]      done_result;
  logic [63:0]     o_data;
  logic [10:0]     o_id;
  logic [7:0]      o_keep;
  logic            o_valid;
  logic            o_ready = 1'b0;
  logic [2:0]      r_data  = '0;
  logic            r_valid = 1'b0;
  logic            r_ready;
  logic            bus_off = 1'b0;
  logic            busy;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int          idx;
    logic [10:0] id;
    logic [63:0] data;
    logic [7:0]  keep;
    logic [2:0]  res;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  can_tx_scheduler #(.NUM_REQ(N), .MAX_RETRY(MR)) dut (
    .clk                      (clk),
    .rst                      (rst),
    .req_tdata                (req_tdata),
    .req_tid                  (req_tid),
    .req_tkeep                (req_tkeep),
    .req_tvalid               (req_tvalid),
    .req_tready               (req_tready),
    .done_valid               (done_valid),
    .done_result              (done_result),
    .stm_send_data_out_tdata  (o_data),
    .stm_send_data_out_tid    (o_id),
    .stm_send_data_out_tkeep  (o_keep),
    .stm_send_data_out_tvalid (o_valid),
    .stm_send_data_out_tready (o_ready),
    .stm_result_in_tdata      (r_data),
    .stm_result_in_tvalid     (r_valid),
    .stm_result_in_tready     (r_ready),
    .status_bus_off           (bus_off),
    .busy                     (busy)
  );

  // ---------------- drivers (no checking) ----------------
  task automatic set_req(input int i, input logic [10:0] id, input logic [63:0] d,
                         input logic [7:0] k, input logic [2:0] res);
    req_tid[i*11 +: 11]  = id;
    req_tdata[i*64 +: 64] = d;
    req_tkeep[i*8 +: 8]  = k;
    req_tvalid[i]        = 1'b1;
    sb.push_back('{i, id, d, k, res});
  endtask

  task automatic wait_grant(output logic [N-1:0] rdy, output bit ok);
    ok = 1'b0; rdy = '0;
    for (int c = 0; c < 30; c++) begin
      #1;
      if (req_tready != '0) begin rdy = req_tready; ok = 1'b1; break; end
      @(negedge clk);
    end
    if (ok) begin
      @(negedge clk);
      for (int i = 0; i < N; i++) if (rdy[i]) req_tvalid[i] = 1'b0;
    end
  endtask

  task automatic wait_send(output logic [10:0] id, output logic [63:0] d,
                           output logic [7:0] k, output int waited);
    waited = -1; id = '0; d = '0; k = '0;
    for (int c = 0; c < 30; c++) begin
      if (o_valid) begin
        id = o_id; d = o_data; k = o_keep; waited = c;
        o_ready = 1'b1; @(negedge clk); o_ready = 1'b0;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic give_result(input logic [2:0] code, output int waited);
    waited = -1;
    for (int c = 0; c < 30; c++) begin
      if (r_ready) begin
        r_data = code; r_valid = 1'b1; waited = c;
        @(negedge clk); r_valid = 1'b0;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic wait_done(output logic [N-1:0] dv, output logic [2:0] res, output int waited);
    waited = -1; dv = '0; res = '0;
    for (int c = 0; c < 30; c++) begin
      if (done_valid != '0) begin
        dv = done_valid; res = done_result; waited = c;
        @(negedge clk);
        break;
      end
      @(negedge clk);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if ({req_tready, done_valid, done_result, o_data, o_id, o_keep, o_valid, r_ready} !== '0) begin
      errors++; $display("FAIL reset_outputs got tready=%h dv=%h res=%h tvalid=%b rready=%b",
                         req_tready, done_valid, done_result, o_valid, r_ready);
    end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_single();
    logic [N-1:0] rdy, dv; bit ok; exp_t e; logic [10:0] id; logic [63:0] d;
    logic [7:0] k; logic [2:0] res; int w;
    set_req(1, 11'h3E9, 64'h1122_3344_5566_7788, 8'h0F, 3'd0);
    wait_grant(rdy, ok);
    e = sb.pop_front();
    checks++;
    if (!ok || rdy !== 4'b0010) begin errors++; $display("FAIL single_grant got %b exp 0010", rdy); end
    wait_send(id, d, k, w);
    checks++;
    if (w !== 0) begin errors++; $display("FAIL single_send_latency got %0d exp 0", w); end
    checks++;
    if ({id, k, d} !== {e.id, e.keep, e.data}) begin
      errors++; $display("FAIL single_frame got id=%h k=%h d=%h exp id=%h k=%h d=%h", id, k, d, e.id, e.keep, e.data);
    end
    give_result(e.res, w);
    wait_done(dv, res, w);
    checks++;
    if (w !== 0 || dv !== 4'b0010 || res !== 3'd0) begin
      errors++; $display("FAIL single_done got wait=%0d dv=%b res=%0d exp wait=0 dv=0010 res=0", w, dv, res);
    end
    #1;
    checks++;
    if (done_valid !== '0 || busy !== 1'b0) begin
      errors++; $display("FAIL single_pulse got dv=%b busy=%b exp 0 0", done_valid, busy);
    end
  endtask

  task automatic test_priority();
    logic [N-1:0] rdy, dv, oh; bit ok; exp_t e; logic [10:0] id; logic [63:0] d;
    logic [7:0] k; logic [2:0] res; int w;
    for (int ph = 0; ph < 2; ph++) begin
      if (ph == 0) begin
        set_req(2, 11'h3D9, 64'hAAAA_0000_0000_0002, 8'hFF, 3'd0);
        set_req(0, 11'h3E9, 64'hAAAA_0000_0000_0000, 8'h03, 3'd0);
      end else begin
        set_req(1, 11'h100, 64'hBBBB_0000_0000_0001, 8'h01, 3'd0);
        set_req(3, 11'h100, 64'hBBBB_0000_0000_0003, 8'h07, 3'd0);
      end
      for (int f = 0; f < 2; f++) begin
        wait_grant(rdy, ok);
        e = sb.pop_front();
        oh = '0; oh[e.idx] = 1'b1;
        checks++;
        if (!ok || rdy !== oh) begin errors++; $display("FAIL prio_grant got %b exp %b", rdy, oh); end
        wait_send(id, d, k, w);
        checks++;
        if (w !== 0 || {id, k, d} !== {e.id, e.keep, e.data}) begin
          errors++; $display("FAIL prio_frame got id=%h d=%h exp id=%h d=%h", id, d, e.id, e.data);
        end
        give_result(e.res, w);
        wait_done(dv, res, w);
        checks++;
        if (dv !== oh || res !== e.res) begin
          errors++; $display("FAIL prio_done got dv=%b res=%0d exp dv=%b res=%0d", dv, res, oh, e.res);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    logic [N-1:0] rdy, dv; bit ok; exp_t e; logic [10:0] id; logic [63:0] d;
    logic [7:0] k; logic [2:0] res; int w; int bad;
    set_req(0, 11'h123, 64'hDEAD_BEEF_0BAD_F00D, 8'hFF, 3'd0);
    wait_grant(rdy, ok);
    e = sb.pop_front();
    req_tid[0 +: 11] = 11'h001;            // changes during service are ignored
    req_tdata[0 +: 64] = 64'h0;
    bad = 0;
    for (int c = 0; c < 10; c++) begin
      if (!o_valid || {o_id, o_keep, o_data} !== {e.id, e.keep, e.data} || done_valid !== '0) bad++;
      @(negedge clk);
    end
    checks++;
    if (bad !== 0) begin errors++; $display("FAIL bp_stable got %0d unstable cycles exp 0", bad); end
    wait_send(id, d, k, w);
    checks++;
    if (w !== 0 || {id, d} !== {e.id, e.data}) begin
      errors++; $display("FAIL bp_frame got id=%h d=%h exp id=%h d=%h", id, d, e.id, e.data);
    end
    give_result(e.res, w);
    wait_done(dv, res, w);
    checks++;
    if (dv !== 4'b0001 || res !== 3'd0) begin
      errors++; $display("FAIL bp_done got dv=%b res=%0d exp 0001 0", dv, res);
    end
  endtask

  task automatic test_retry();
    logic [N-1:0] rdy, dv; bit ok; exp_t e; logic [10:0] id; logic [63:0] d;
    logic [7:0] k; logic [2:0] res; int w; int sends; int exp_sends;
    logic [2:0] codes[3];
    for (int s = 0; s < 2; s++) begin
`ifdef CAN_TX_SCHED_RETRY_EN
      if (s == 0) begin codes = '{3'd3, 3'd3, 3'd3}; exp_sends = 3; end
      else        begin codes = '{3'd5, 3'd0, 3'd0}; exp_sends = 2; end
      set_req(3, 11'h055, 64'h0000_0000_0000_00C0 + 64'(s), 8'h01, (s == 0) ? 3'd3 : 3'd0);
`else
      if (s == 0) begin codes = '{3'd3, 3'd0, 3'd0}; exp_sends = 1; end
      else        begin codes = '{3'd5, 3'd0, 3'd0}; exp_sends = 1; end
      set_req(3, 11'h055, 64'h0000_0000_0000_00C0 + 64'(s), 8'h01, (s == 0) ? 3'd3 : 3'd5);
`endif
      wait_grant(rdy, ok);
      e = sb.pop_front();
      sends = 0; dv = '0; res = '0;
      for (int a = 0; a < 6; a++) begin
        wait_send(id, d, k, w);
        if (w < 0) break;
        sends++;
        give_result((sends <= 3) ? codes[sends-1] : 3'd0, w);
        if (done_valid != '0) begin wait_done(dv, res, w); break; end
      end
      checks++;
      if (sends !== exp_sends) begin errors++; $display("FAIL retry_sends got %0d exp %0d", sends, exp_sends); end
      checks++;
      if (dv !== 4'b1000 || res !== e.res) begin
        errors++; $display("FAIL retry_result got dv=%b res=%0d exp 1000 %0d", dv, res, e.res);
      end
    end
  endtask

  task automatic test_bus_off();
    logic [N-1:0] rdy, dv; bit ok; exp_t e; logic [10:0] id; logic [63:0] d;
    logic [7:0] k; logic [2:0] res; int w; int bad;
    set_req(0, 11'h200, 64'h0000_1111_2222_3333, 8'h3C, 3'd3);
    wait_grant(rdy, ok);
    e = sb.pop_front();
    wait_send(id, d, k, w);
    bus_off = 1'b1;
    give_result(3'd3, w);
    wait_done(dv, res, w);
    checks++;
    if (w !== 0 || dv !== 4'b0001 || res !== 3'd3) begin
      errors++; $display("FAIL busoff_fail_done got wait=%0d dv=%b res=%0d exp 0 0001 3", w, dv, res);
    end
    checks++;
    if (o_valid !== 1'b0) begin errors++; $display("FAIL busoff_no_retry got tvalid=%b exp 0", o_valid); end
    set_req(2, 11'h010, 64'h0000_0000_0000_0BAD, 8'h0F, 3'd0);
    bad = 0;
    for (int c = 0; c < 6; c++) begin
      #1;
      if (req_tready !== '0 || busy !== 1'b0) bad++;
      @(negedge clk);
    end
    checks++;
    if (bad !== 0) begin errors++; $display("FAIL busoff_no_grant got %0d grant cycles exp 0", bad); end
    bus_off = 1'b0;
    wait_grant(rdy, ok);
    e = sb.pop_front();
    checks++;
    if (!ok || rdy !== 4'b0100) begin errors++; $display("FAIL busoff_release_grant got %b exp 0100", rdy); end
    wait_send(id, d, k, w);
    give_result(e.res, w);
    wait_done(dv, res, w);
    checks++;
    if (dv !== 4'b0100 || res !== 3'd0) begin
      errors++; $display("FAIL busoff_release_done got dv=%b res=%0d exp 0100 0", dv, res);
    end
  endtask

  task automatic test_reset_mid();
    logic [N-1:0] rdy, dv; bit ok; exp_t e; logic [10:0] id; logic [63:0] d;
    logic [7:0] k; logic [2:0] res; int w; int bad;
    set_req(1, 11'h321, 64'h5555_6666_7777_8888, 8'hFF, 3'd0);
    wait_grant(rdy, ok);
    void'(sb.pop_front());
    wait_send(id, d, k, w);
    #1;
    checks++;
    if (r_ready !== 1'b1) begin errors++; $display("FAIL midrst_in_wait got rready=%b exp 1", r_ready); end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({req_tready, done_valid, done_result, o_data, o_id, o_keep, o_valid, r_ready, busy} !== '0) begin
      errors++; $display("FAIL midrst_async got tvalid=%b rready=%b busy=%b dv=%b id=%h exp all 0",
                         o_valid, r_ready, busy, done_valid, o_id);
    end
    @(negedge clk);
    rst = 1'b0;
    bad = 0;
    for (int c = 0; c < 4; c++) begin
      if (done_valid !== '0 || busy !== 1'b0) bad++;
      @(negedge clk);
    end
    checks++;
    if (bad !== 0) begin errors++; $display("FAIL midrst_no_done got %0d bad cycles exp 0", bad); end
    set_req(3, 11'h7FF, 64'h0123_4567_89AB_CDEF, 8'h80, 3'd0);
    wait_grant(rdy, ok);
    e = sb.pop_front();
    checks++;
    if (!ok || rdy !== 4'b1000) begin errors++; $display("FAIL midrst_regrant got %b exp 1000", rdy); end
    wait_send(id, d, k, w);
    checks++;
    if ({id, k, d} !== {e.id, e.keep, e.data}) begin
      errors++; $display("FAIL midrst_frame got id=%h d=%h exp id=%h d=%h", id, d, e.id, e.data);
    end
    give_result(e.res, w);
    wait_done(dv, res, w);
    checks++;
    if (dv !== 4'b1000 || res !== 3'd0) begin
      errors++; $display("FAIL midrst_done got dv=%b res=%0d exp 1000 0", dv, res);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_priority();
    test_backpressure();
    test_retry();
    test_bus_off();
    test_reset_mid();
    checks++;
    if (sb.size() != 0) begin errors++; $display("FAIL scoreboard_left got %0d exp 0", sb.size()); end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp completion");
    $fatal(1, "watchdog expired");
  end

endmodule
